// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes, type-field placement, sender FSM
// encodings and the packet-framing helpers built on them.
package noc_pkg;

  // The flit type occupies the TYPE_W most significant bits of a flit.
  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GATED = 2'd2
  } state_e;

  // Packet-open status once a flit of type t has been accepted.
  function automatic logic pkt_open_after(input flit_type_e t, input logic in_pkt);
    case (t)
      FLIT_HEAD:               return 1'b1;
      FLIT_TAIL, FLIT_SINGLE:  return 1'b0;
      default:                 return in_pkt;
    endcase
  endfunction

  function automatic logic framing_error(input flit_type_e t, input logic in_pkt);
    return (t == FLIT_BODY || t == FLIT_TAIL) ? ~in_pkt : in_pkt;
  endfunction

endpackage

// File: rtl/flit_sender.sv
// Pops flits from an upstream queue and presents them on a valid/ready link,
// with packet-aware power-gate handshake. Optional stats: SENDER_STATS_EN.
//   state    | meaning
//   ST_IDLE  | no flit held, fetch when queue non-empty
//   ST_SEND  | flit held on data_o, valid_o=1
//   ST_GATED | between packets, safe to power-gate, pg_ack=1
module flit_sender
  import noc_pkg::*;
#(
  parameter int BUS_SIZE = 32,
  parameter int CNT_SIZE = 16
) (
  input  logic                clk,
  input  logic                a_rst,
  input  logic                q_empty,
  input  logic [BUS_SIZE-1:0] q_data,
  output logic                readed,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [BUS_SIZE-1:0] data_o,
  input  logic                pg_req,
  output logic                pg_ack,
  output logic                proto_err
`ifdef SENDER_STATS_EN
  ,
  output logic [CNT_SIZE-1:0] flit_cnt,
  output logic [CNT_SIZE-1:0] pkt_cnt
`endif
);

  if (CNT_SIZE < 1) begin : g_bad_cnt_size
    $error("CNT_SIZE must be at least 1");
  end

  state_e     r_state;
  logic       r_in_pkt;
  flit_type_e w_out_type;
  logic       w_accept;
  logic       w_next_in_pkt;
  logic       w_pkt_open;
  logic       w_fetch_ok;

  assign w_out_type    = flit_type_e'(data_o[BUS_SIZE-1 -: TYPE_W]);
  assign w_accept      = valid_o & ready_i;
  assign w_next_in_pkt = w_accept ? pkt_open_after(w_out_type, r_in_pkt) : r_in_pkt;

  // A held HEAD already commits us to its packet, so the next flit may be
  // fetched under pg_req even though in_pkt only rises on acceptance.
  assign w_pkt_open = (r_state == ST_SEND) ? pkt_open_after(w_out_type, r_in_pkt) : r_in_pkt;
  assign w_fetch_ok = ~pg_req | w_pkt_open;

  assign readed = ~a_rst & ~q_empty & w_fetch_ok &
                  ((r_state == ST_IDLE) | ((r_state == ST_SEND) & ready_i));

  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_state   <= ST_IDLE;
      r_in_pkt  <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      pg_ack    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_in_pkt <= w_next_in_pkt;
        if (framing_error(w_out_type, r_in_pkt)) proto_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (readed) begin
            data_o  <= q_data;
            valid_o <= 1'b1;
            r_state <= ST_SEND;
          end else if (pg_req && !r_in_pkt) begin
            pg_ack  <= 1'b1;
            r_state <= ST_GATED;
          end
        end
        ST_SEND: begin
          if (readed) begin
            data_o <= q_data;
          end else if (ready_i) begin
            valid_o <= 1'b0;
            if (pg_req && !w_next_in_pkt) begin
              pg_ack  <= 1'b1;
              r_state <= ST_GATED;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GATED: begin
          if (!pg_req) begin
            pg_ack  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          pg_ack  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SENDER_STATS_EN
  always_ff @(posedge clk) begin
    if (a_rst) begin
      flit_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (w_accept) begin
      flit_cnt <= flit_cnt + 1'b1;
      if (w_out_type == FLIT_TAIL || w_out_type == FLIT_SINGLE) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_sender.sv
// Bench for flit_sender: directed scenarios plus random traffic, checked each
// cycle against a packet-level reference model.
module tb_flit_sender;

  localparam int BW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          a_rst, q_empty, readed, valid_o, ready_i, pg_req, pg_ack, proto_err;
  logic [BW-1:0] q_data, data_o;
`ifdef SENDER_STATS_EN
  logic [CW-1:0] flit_cnt, pkt_cnt;
`endif

  always #5 clk = ~clk;

  flit_sender #(.BUS_SIZE(BW), .CNT_SIZE(CW)) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .readed    (readed),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .pg_req    (pg_req),
    .pg_ack    (pg_ack),
    .proto_err (proto_err)
`ifdef SENDER_STATS_EN
    ,
    .flit_cnt  (flit_cnt),
    .pkt_cnt   (pkt_cnt)
`endif
  );

  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic [BW-1:0] q[$];

  // Reference model: is a flit on the link, are we parked, packet framing.
  bit            m_busy, m_gated, m_in_pkt, m_err, m_rd;
  logic [BW-1:0] m_data;
  int            m_flits, m_pkts;

  int vectors = 0;
  int miscompares = 0;

  function automatic bit opens(input logic [1:0] t, input bit cur);
    if (t == T_HEAD) return 1'b1;
    if (t == T_TAIL || t == T_SINGLE) return 1'b0;
    return cur;
  endfunction

  function automatic bit bad_frame(input logic [1:0] t, input bit cur);
    return (t == T_BODY || t == T_TAIL) ? !cur : cur;
  endfunction

  function automatic logic [BW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check, then advance model and queue.
  task automatic cycle(input bit rdy, input bit pg, input bit rst);
    bit            acc, new_in;
    logic [1:0]    t;
    logic [BW-1:0] head;
    ready_i = rdy;
    pg_req  = pg;
    a_rst   = rst;
    q_empty = (q.size() == 0);
    head    = q_empty ? '0 : q[0];
    q_data  = head;
    #1;
    t    = m_data[BW-1 -: 2];
    m_rd = !rst && (q.size() != 0) && !m_gated && (!m_busy || rdy) &&
           (!pg || (m_busy ? opens(t, m_in_pkt) : m_in_pkt));
    chk("readed", readed, m_rd);
    chk("valid_o", valid_o, m_busy);
    chk("data_o", data_o, m_data);
    chk("pg_ack", pg_ack, m_gated);
    chk("proto_err", proto_err, m_err);
`ifdef SENDER_STATS_EN
    chk("flit_cnt", flit_cnt, m_flits % (1 << CW));
    chk("pkt_cnt", pkt_cnt, m_pkts % (1 << CW));
`endif
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_gated = 0; m_in_pkt = 0; m_err = 0; m_data = '0;
      m_flits = 0; m_pkts = 0;
    end else begin
      acc    = m_busy && rdy;
      new_in = m_in_pkt;
      if (acc) begin
        m_flits++;
        if (t == T_TAIL || t == T_SINGLE) m_pkts++;
        if (bad_frame(t, m_in_pkt)) m_err = 1;
        new_in = opens(t, m_in_pkt);
      end
      if (m_rd) begin
        m_busy = 1;
        m_data = head;
      end else if (m_busy && rdy) begin
        m_busy  = 0;
        m_gated = pg && !new_in;
      end else if (!m_busy && !m_gated && pg && !m_in_pkt) begin
        m_gated = 1;
      end else if (m_gated && !pg) begin
        m_gated = 0;
      end
      m_in_pkt = new_in;
    end
    if (m_rd) void'(q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b1; ready_i = 1'b0; pg_req = 1'b0; q_empty = 1'b1; q_data = '0;
    m_busy = 0; m_gated = 0; m_in_pkt = 0; m_err = 0; m_data = '0; m_flits = 0; m_pkts = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    cycle(0, 0, 1);

    // four-flit burst at full rate
    q.push_back(mk(T_HEAD, 30'h11)); q.push_back(mk(T_BODY, 30'h22));
    q.push_back(mk(T_BODY, 30'h33)); q.push_back(mk(T_TAIL, 30'h44));
    repeat (7) cycle(1, 0, 0);
    chk("burst_drained", q.size(), 0);

    // backpressure on 0x4000_00AA, then close the packet
    q.push_back(32'h4000_00AA);
    cycle(0, 0, 0);
    repeat (3) cycle(0, 0, 0);
    chk("held_data", data_o, 32'h4000_00AA);
    cycle(1, 0, 0);
    repeat (2) cycle(1, 0, 0);
    q.push_back(mk(T_TAIL, 30'hBB));
    repeat (3) cycle(1, 0, 0);

    // power-gate request mid-packet
    q.push_back(mk(T_HEAD, 30'h101)); q.push_back(mk(T_BODY, 30'h102));
    q.push_back(mk(T_TAIL, 30'h103)); q.push_back(mk(T_HEAD, 30'h201));
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    repeat (6) cycle(1, 1, 0);
    chk("gated_ack", pg_ack, 1'b1);
    chk("next_head_waits", q.size(), 1);
    repeat (3) cycle(1, 0, 0);
    q.push_back(mk(T_TAIL, 30'h202));
    repeat (3) cycle(1, 0, 0);

    // orphan BODY raises sticky proto_err until reset
    q.push_back(32'h0000_0001);
    repeat (3) cycle(1, 0, 0);
    q.push_back(mk(T_SINGLE, 30'h5));
    repeat (3) cycle(1, 0, 0);
    chk("err_sticky", proto_err, 1'b1);
    cycle(1, 0, 1);
    cycle(1, 0, 0);

    // reset while a flit is held
    q.push_back(mk(T_SINGLE, 30'h7)); q.push_back(mk(T_SINGLE, 30'h8));
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    q.delete();
    cycle(0, 0, 0);
    chk("rst_data", data_o, 0);

`ifdef SENDER_STATS_EN
    // 2**CW + 1 accepted flits wrap the counters to one
    for (int i = 0; i < (1 << CW) + 1; i++) q.push_back(mk(T_SINGLE, 30'(i)));
    repeat ((1 << CW) + 4) cycle(1, 0, 0);
    chk("flit_cnt_wrap", flit_cnt, 1);
    chk("pkt_cnt_wrap", pkt_cnt, 1);
`endif

    // random traffic
    begin
      bit pg = 0;
      for (int i = 0; i < 500; i++) begin
        if (q.size() < 6 && $urandom_range(0, 2) != 0)
          q.push_back(mk(2'($urandom_range(0, 3)), 30'($urandom)));
        if ($urandom_range(0, 15) == 0) pg = !pg;
        cycle(1'($urandom_range(0, 3) != 0), pg, $urandom_range(0, 99) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flit_sender.md
FLIT_SENDER -- requirements
Module: flit_sender

Interface
REQ-001 SHALL have parameter BUS_SIZE, default 32: flit width in bits.
REQ-002 SHALL have parameter CNT_SIZE, default 16: statistics counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on posedge.
REQ-004 SHALL have port a_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port q_empty, input, 1 bit: upstream queue empty flag.
REQ-006 SHALL have port q_data, input, BUS_SIZE bits: upstream queue head flit (async read).
REQ-007 SHALL have port readed, output, 1 bit: one-cycle pop strobe to the upstream queue.
REQ-008 SHALL have port valid_o, output, 1 bit: downstream flit valid.
REQ-009 SHALL have port ready_i, input, 1 bit: downstream accept.
REQ-010 SHALL have port data_o, output, BUS_SIZE bits: downstream flit.
REQ-011 SHALL have port pg_req, input, 1 bit: power-gate request.
REQ-012 SHALL have port pg_ack, output, 1 bit: safe-to-gate acknowledge.
REQ-013 SHALL have port proto_err, output, 1 bit: sticky framing-error flag.
REQ-014 SHALL, with SENDER_STATS_EN defined, have ports flit_cnt and pkt_cnt, output, CNT_SIZE bits each.

Function
REQ-015 SHALL decode flit type from data bits [BUS_SIZE-1:BUS_SIZE-2]: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE.
REQ-016 SHALL implement FSM states IDLE (valid_o=0), SEND (valid_o=1), GATED (valid_o=0, pg_ack=1).
REQ-017 SHALL drive readed combinationally = ~q_empty & fetch_ok & (state==IDLE | (state==SEND & ready_i)); readed SHALL never be 1 while q_empty=1.
REQ-018 SHALL, on any cycle with readed=1, register q_data into data_o and be in SEND next cycle (latency one cycle from queue non-empty to valid_o).
REQ-019 SHALL, in SEND with ready_i=1 and readed=0, go to IDLE (or GATED per REQ-022); with ready_i=0, hold data_o and valid_o unchanged.
REQ-020 SHALL sustain one flit per cycle when ready_i=1 and the queue stays non-empty.
REQ-021 SHALL track in_pkt: set on accepted HEAD, cleared on accepted TAIL; SINGLE leaves it 0; "accepted" means valid_o & ready_i.
REQ-022 SHALL compute fetch_ok = ~pg_req | in_pkt | fetched-flit-pending-completion; new packets SHALL not start while pg_req=1; on pg_req=1 with state IDLE and in_pkt=0, go to GATED.
REQ-023 SHALL leave GATED for IDLE one cycle after pg_req falls; pg_ack SHALL be 1 only in GATED.
REQ-024 SHALL set proto_err on accepted BODY/TAIL with in_pkt=0, or accepted HEAD/SINGLE with in_pkt=1; flit still forwarded, in_pkt updated per REQ-021.

Reset
REQ-025 SHALL, on a_rst=1 at posedge clk, force state IDLE, valid_o=0, data_o=0, in_pkt=0, proto_err=0, pg_ack=0, counters 0, and readed SHALL be 0 while a_rst=1.
REQ-026 SHALL drop any flit in flight on reset mid-transfer without further readed pulses.

Configuration
REQ-027 SHALL, with SENDER_STATS_EN defined, count accepted flits in flit_cnt and accepted TAIL/SINGLE flits in pkt_cnt, both wrapping modulo 2**CNT_SIZE.
REQ-028 SHALL, without SENDER_STATS_EN, omit the counters and their ports entirely; all other behaviour identical.

Structure
REQ-029 SHALL take flit-type codes, type-field position and FSM state encodings from the shared package noc_pkg.
REQ-030 SHALL be a single module with no sub-module instances.

Verification
REQ-031 SHALL verify: queue holds 4 flits, ready_i=1 constantly -> readed high 4 consecutive cycles, valid_o high 4 cycles starting one cycle later, data order preserved.
REQ-032 SHALL verify: ready_i=0 for 3 cycles with valid flit 0x4000_00AA -> data_o stable, readed=0, transfer on ready_i rise, then IDLE if queue empty.
REQ-033 SHALL verify: pg_req raised after HEAD accepted, packet HEAD,BODY,TAIL queued -> BODY and TAIL still sent, then GATED, pg_ack=1, no readed while next HEAD waits; pg_req low -> resume.
REQ-034 SHALL verify: BODY flit 0x0000_0001 sent in IDLE with in_pkt=0 -> proto_err=1 and stays 1 until a_rst.
REQ-035 SHALL verify: a_rst asserted during SEND -> next cycle valid_o=0, data_o=0, readed=0; with SENDER_STATS_EN, 2**CNT_SIZE+1 accepted flits -> flit_cnt=1.
